alu_issue_ctrl: RTL and testbench

- Sequential initiator that drives the combinational ALU: accepts one operation request per valid/ready handshake, registers and presents the operands and control code to the ALU, then captures the result.
- Returns the captured result on a valid/ready response channel.
- Owns the architectural carry flag for ADDC/SUBC chaining, and a sticky exception flag for EXCEPTION/undefined opcodes.
- Sits between the decode stage and the ALU in the RISC datapath.

---
 rtl/alu_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one request at a time to the combinational ALU,
// captures its result and returns it on a valid/ready response channel.
// Owns the ADDC/SUBC carry flag and a sticky exception flag.
// Optional macro ALU_ISSUE_PIPE_EN: lets HOLD accept the next request
// in the same cycle as the response handshake (II of 2 cycles).
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_req_valid/o_req_ready, i_req_op/A/B   request channel
//   o_alu_ctrl/A/B, i_alu_result             ALU interface
//   o_rsp_valid/i_rsp_ready, o_rsp_data      response channel
//   o_carry, o_exception, i_exc_clr          status flags
module alu_issue_ctrl #(
  parameter int NB_REGISTERS = 34,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_CTRL      = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [NB_CTRL-1:0]      i_req_op,
  input  logic [NB_REGISTERS-1:0] i_req_A,
  input  logic [NB_REGISTERS-1:0] i_req_B,
  output logic [NB_CTRL-1:0]      o_alu_ctrl,
  output logic [NB_REGISTERS-1:0] o_alu_A,
  output logic [NB_REGISTERS-1:0] o_alu_B,
  input  logic [NB_REGISTERS-1:0] i_alu_result,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [NB_REGISTERS-1:0] o_rsp_data,
  output logic                    o_carry,
  output logic                    o_exception,
  input  logic                    i_exc_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [NB_CTRL-1:0] CTRL_IDLE = NB_CTRL'(4);
  localparam logic [NB_CTRL-1:0] OP_LAST   = NB_CTRL'(3);
  localparam logic [NB_REGISTERS-1:0] CMASK =
    NB_REGISTERS'(1) << DATA_WIDTH;

  state_t                  r_state;
  state_t                  w_next;
  logic [NB_CTRL-1:0]      r_alu_ctrl;
  logic [NB_REGISTERS-1:0] r_alu_A;
  logic [NB_REGISTERS-1:0] r_alu_B;
  logic [NB_REGISTERS-1:0] r_rsp_data;
  logic                    r_carry;
  logic                    r_exception;

  logic                    w_op_ok;
  logic                    w_cin;
  logic [NB_REGISTERS-1:0] w_A_shaped;
  logic                    w_load;
  logic                    w_err_set;
  logic                    w_rsp_done;
  logic                    w_req_ready;

  assign w_op_ok = (i_req_op <= OP_LAST);
  // ADDC/SUBC (op bit 1 set) chain the stored carry into bit DATA_WIDTH
  assign w_cin   = i_req_op[1] & r_carry;
  assign w_A_shaped = (i_req_A & ~CMASK) |
                      (w_cin ? CMASK : '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (i_req_valid)
          w_next = w_op_ok ? S_EXEC : S_ERR;
      end
      S_EXEC: w_next = S_HOLD;
      S_HOLD: begin
`ifdef ALU_ISSUE_PIPE_EN
        w_req_ready = i_rsp_ready;
        if (i_rsp_ready) begin
          if (i_req_valid)
            w_next = w_op_ok ? S_EXEC : S_ERR;
          else
            w_next = S_IDLE;
        end
`else
        if (i_rsp_ready) w_next = S_IDLE;
`endif
      end
      S_ERR: begin
        if (i_exc_clr) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_load     = (r_state == S_IDLE || r_state == S_HOLD) &&
                      (w_next == S_EXEC);
  assign w_err_set  = (r_state != S_ERR) && (w_next == S_ERR);
  assign w_rsp_done = (r_state == S_HOLD) && i_rsp_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_alu_ctrl  <= CTRL_IDLE;
      r_alu_A     <= '0;
      r_alu_B     <= '0;
      r_rsp_data  <= '0;
      r_carry     <= 1'b0;
      r_exception <= 1'b0;
    end else begin
      if (w_load) begin
        r_alu_ctrl <= i_req_op;
        r_alu_A    <= w_A_shaped;
        r_alu_B    <= i_req_B;
      end else if (w_rsp_done || w_err_set) begin
        r_alu_ctrl <= CTRL_IDLE;
        r_alu_A    <= '0;
        r_alu_B    <= '0;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data <= i_alu_result;
        r_carry    <= i_alu_result[DATA_WIDTH];
      end
      if (w_err_set) begin
        r_exception <= 1'b1;
      end else if (r_state == S_ERR && i_exc_clr) begin
        r_exception <= 1'b0;
        r_carry     <= 1'b0;
      end
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_rsp_valid = (r_state == S_HOLD);
  assign o_alu_ctrl  = r_alu_ctrl;
  assign o_alu_A     = r_alu_A;
  assign o_alu_B     = r_alu_B;
  assign o_rsp_data  = r_rsp_data;
  assign o_carry     = r_carry;
  assign o_exception = r_exception;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a small
// behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [33:0] req_A;
  logic [33:0] req_B;
  logic [2:0]  alu_ctrl;
  logic [33:0] alu_A;
  logic [33:0] alu_B;
  logic [33:0] alu_res;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [33:0] rsp_data;
  logic        carry;
  logic        exc;
  logic        exc_clr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_A      (req_A),
    .i_req_B      (req_B),
    .o_alu_ctrl   (alu_ctrl),
    .o_alu_A      (alu_A),
    .o_alu_B      (alu_B),
    .i_alu_result (alu_res),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_carry      (carry),
    .o_exception  (exc),
    .i_exc_clr    (exc_clr)
  );

  // ALU model: bit 32 of A is the carry/borrow in
  logic [32:0] s;
  always_comb begin
    s = '0;
    case (alu_ctrl)
      3'd0, 3'd2: s = {1'b0, alu_A[31:0]} + {1'b0, alu_B[31:0]}
                      + {32'd0, alu_A[32]};
      3'd1, 3'd3: s = {1'b0, alu_A[31:0]} - {1'b0, alu_B[31:0]}
                      - {32'd0, alu_A[32]};
      default:    s = '0;
    endcase
    alu_res = {1'b0, s};
  end

  task automatic chk(input string tag,
                     input logic [33:0] got,
                     input logic [33:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [33:0] a,
                       input logic [33:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_A     = a;
    req_B     = b;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_op = 0; req_A = 0; req_B = 0;
    rsp_ready = 1'b1; exc_clr = 1'b0;
    #12;
    chk("rst_ready", 34'(req_ready), 34'd1);
    chk("rst_valid", 34'(rsp_valid), 34'd0);
    chk("rst_data",  rsp_data, 34'd0);
    chk("rst_carry", 34'(carry), 34'd0);
    chk("rst_exc",   34'(exc), 34'd0);
    chk("rst_ctrl",  34'(alu_ctrl), 34'd4);
    chk("rst_A",     alu_A, 34'd0);
    chk("rst_B",     alu_B, 34'd0);
    rst = 1'b0;
    tick();

    // ADD -5 + 1
    issue(3'd0, 34'h3FFFFFFFB, 34'd1);
    chk("add_ex_ctrl",  34'(alu_ctrl), 34'd0);
    chk("add_ex_valid", 34'(rsp_valid), 34'd0);
    chk("add_ex_ready", 34'(req_ready), 34'd0);
    chk("add_ex_A",     alu_A, 34'h2FFFFFFFB);
    tick();
    chk("add_h_ctrl",  34'(alu_ctrl), 34'd0);
    chk("add_h_valid", 34'(rsp_valid), 34'd1);
    chk("add_h_data",  34'(rsp_data[31:0]), 34'hFFFFFFFC);
    chk("add_h_carry", 34'(carry), 34'd0);
    tick();
    chk("add_i_valid", 34'(rsp_valid), 34'd0);
    chk("add_i_ready", 34'(req_ready), 34'd1);
    chk("add_i_ctrl",  34'(alu_ctrl), 34'd4);

    // carry chain
    issue(3'd0, 34'hFFFFFFFF, 34'd1);
    tick();
    chk("wrap_data",  34'(rsp_data[31:0]), 34'd0);
    chk("wrap_carry", 34'(carry), 34'd1);
    tick();
    issue(3'd2, 34'd0, 34'd0);
    chk("addc_A", alu_A, 34'h100000000);
    tick();
    chk("addc_data",  34'(rsp_data[31:0]), 34'd1);
    chk("addc_carry", 34'(carry), 34'd0);
    tick();

    // back-pressure
    rsp_ready = 1'b0;
    issue(3'd1, 34'd10, 34'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 34'(rsp_valid), 34'd1);
      chk("bp_data",  34'(rsp_data[31:0]), 34'd7);
      chk("bp_ready", 34'(req_ready), 34'd0);
      chk("bp_ctrl",  34'(alu_ctrl), 34'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_done_valid", 34'(rsp_valid), 34'd0);
    chk("bp_done_ready", 34'(req_ready), 34'd1);

    // exception path; carry set first to see it survive ERR
    issue(3'd0, 34'hFFFFFFFF, 34'd1);
    tick();
    tick();
    chk("pre_exc_carry", 34'(carry), 34'd1);
    issue(3'd4, 34'd5, 34'd5);
    chk("exc4_exc",   34'(exc), 34'd1);
    chk("exc4_ready", 34'(req_ready), 34'd0);
    chk("exc4_valid", 34'(rsp_valid), 34'd0);
    req_valid = 1'b1; req_op = 3'd7;
    tick(); tick(); tick();
    chk("exc7_wait_exc",   34'(exc), 34'd1);
    chk("exc7_wait_ready", 34'(req_ready), 34'd0);
    chk("exc7_wait_valid", 34'(rsp_valid), 34'd0);
    chk("err_carry_kept",  34'(carry), 34'd1);
    exc_clr = 1'b1;
    tick();
    exc_clr = 1'b0;
    chk("clr_exc",   34'(exc), 34'd0);
    chk("clr_ready", 34'(req_ready), 34'd1);
    chk("clr_carry", 34'(carry), 34'd0);
    tick();
    req_valid = 1'b0;
    chk("exc7_exc",   34'(exc), 34'd1);
    chk("exc7_ready", 34'(req_ready), 34'd0);
    exc_clr = 1'b1;
    tick();
    exc_clr = 1'b0;
    chk("clr2_exc", 34'(exc), 34'd0);

    // async reset in HOLD
    rsp_ready = 1'b0;
    issue(3'd0, 34'hFFFFFFFF, 34'd1);
    tick();
    chk("prerst_valid", 34'(rsp_valid), 34'd1);
    chk("prerst_carry", 34'(carry), 34'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 34'(rsp_valid), 34'd0);
    chk("arst_ready", 34'(req_ready), 34'd1);
    chk("arst_ctrl",  34'(alu_ctrl), 34'd4);
    chk("arst_carry", 34'(carry), 34'd0);
    chk("arst_data",  rsp_data, 34'd0);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    tick();

`ifdef ALU_ISSUE_PIPE_EN
    // back-to-back ADDs, one response every 2 cycles
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_op    = 3'd0;
      req_A     = 34'(k);
      req_B     = 34'd10;
      tick();
      chk("pipe_ex_valid", 34'(rsp_valid), 34'd0);
      chk("pipe_ex_ctrl",  34'(alu_ctrl), 34'd0);
      tick();
      chk("pipe_h_valid", 34'(rsp_valid), 34'd1);
      chk("pipe_h_data",  rsp_data, 34'(k + 10));
      chk("pipe_h_ready", 34'(req_ready), 34'd1);
    end
    req_valid = 1'b0;
    tick();
    chk("pipe_end_valid", 34'(rsp_valid), 34'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
